mem_port_arbiter: RTL and testbench

- Shares one SRAM-like memory bus between the instruction-fetch requester and the data-access requester of the 5-stage core.
- Grants one requester at a time and registers the granted request.
- Runs a single-outstanding req / addr_ok / data_ok transaction on the shared bus.
- Routes the response back to the owner. Sits between the IF/EX/MEM stages and the external bus bridge.

---
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester/bus signal bundle for mem_port_arbiter
//
// Groups the fetch port, the load/store port and the shared SRAM-like bus.
//   master : arbiter view (takes requests, drives ok/rdata and bus request fields)
//   slave  : environment view (requesters plus bus bridge)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction-fetch requester
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    // data-access requester
    logic                data_req;
    logic                data_wr;
    logic [1:0]          data_size;
    logic [DATA_W/8-1:0] data_wstrb;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    logic [DATA_W-1:0]   data_rdata;

    // shared bus towards the bridge
    logic                bus_req;
    logic                bus_wr;
    logic [1:0]          bus_size;
    logic [DATA_W/8-1:0] bus_wstrb;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic                bus_addr_ok;
    logic                bus_data_ok;
    logic [DATA_W-1:0]   bus_rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one single-outstanding SRAM-like bus
//
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   port   : mem_port_arbiter_if.master (fetch port, load/store port, shared bus)
//   busy   : transaction in flight (FSM not IDLE)
//   owner  : requester owning the bus, 0 = inst, 1 = data (valid while busy)
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    mem_port_arbiter_if.master   port,
    output logic                 busy,
    output logic                 owner
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    starve_q,     starve_d;
    logic                owner_q,      owner_d;
    logic                wr_q,         wr_d;
    logic [1:0]          size_q,       size_d;
    logic [STRB_W-1:0]   wstrb_q,      wstrb_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

    logic grant_data;
    logic grant_inst;
    logic addr_fire;
    logic resp_fire;

    // A data_ok that arrives before the address is accepted is not a response.
    assign addr_fire = (state_q == S_ADDR) && port.bus_addr_ok;
    assign resp_fire = (addr_fire && port.bus_data_ok) ||
                       ((state_q == S_DATA) && port.bus_data_ok);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= '0;
            wstrb_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        size_d       = size_q;
        wstrb_d      = wstrb_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        grant_data   = 1'b0;
        grant_inst   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Data normally wins; once it has taken STARVE_LIMIT grants in a
                // row over a waiting fetch, the fetch gets one slot.
                grant_data = port.data_req &&
                             !((starve_q == STARVE_MAX) && port.inst_req);
                grant_inst = !grant_data && port.inst_req;
                if (grant_data) begin
                    owner_d  = 1'b1;
                    wr_d     = port.data_wr;
                    size_d   = port.data_size;
                    wstrb_d  = port.data_wstrb;
                    addr_d   = port.data_addr;
                    wdata_d  = port.data_wdata;
                    starve_d = port.inst_req ? starve_q + CNT_W'(1) : '0;
                    state_d  = S_ADDR;
                end else if (grant_inst) begin
                    owner_d  = 1'b0;
                    wr_d     = 1'b0;
                    size_d   = 2'd2;
                    wstrb_d  = '0;
                    addr_d   = port.inst_addr;
                    wdata_d  = '0;
                    starve_d = '0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (port.bus_addr_ok) begin
                    state_d = port.bus_data_ok ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (port.bus_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (resp_fire) begin
            if (owner_q) begin
                data_rdata_d = port.bus_rdata;
            end else begin
                inst_rdata_d = port.bus_rdata;
            end
        end
    end

    always_comb begin
        port.bus_req      = (state_q == S_ADDR);
        port.bus_wr       = wr_q;
        port.bus_size     = size_q;
        port.bus_wstrb    = wstrb_q;
        port.bus_addr     = addr_q;
        port.bus_wdata    = wdata_q;

        port.inst_addr_ok = addr_fire && !owner_q;
        port.data_addr_ok = addr_fire &&  owner_q;
        port.inst_data_ok = resp_fire && !owner_q;
        port.data_data_ok = resp_fire &&  owner_q;

        // Response cycle forwards bus_rdata; otherwise the captured copy holds.
        port.inst_rdata   = (resp_fire && !owner_q) ? port.bus_rdata : inst_rdata_q;
        port.data_rdata   = (resp_fire &&  owner_q) ? port.bus_rdata : data_rdata_q;

        busy  = (state_q != S_IDLE);
        owner = owner_q;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic busy;
    logic owner;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .port   (m.master),
        .busy   (busy),
        .owner  (owner)
    );

    typedef struct {
        string       name;
        bit          is_data;
        bit          wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;       // -1: addr_ok+data_ok together, else DATA cycles before data_ok
        logic [31:0] exp_addr;
        bit          exp_wr;
        logic [1:0]  exp_size;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        bit          owner;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[7];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic wait_bus_req(input string name, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (m.bus_req === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s_bus_req_timeout actual=0 required=1", name);
        end
    endtask

    task automatic clear_inputs();
        m.inst_req    = 1'b0;
        m.data_req    = 1'b0;
        m.bus_addr_ok = 1'b0;
        m.bus_data_ok = 1'b0;
    endtask

    // Response monitor: every data_ok pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && (m.inst_data_ok === 1'b1 || m.data_data_ok === 1'b1)) begin
            chk("sb_both_data_ok", {m.inst_data_ok, m.data_data_ok} == 2'b11, 0);
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected_data_ok actual=1 required=0");
            end else begin
                e = sb_q.pop_front();
                chk("sb_owner", m.data_data_ok, e.owner);
                chk("sb_rdata", e.owner ? m.data_rdata : m.inst_rdata, e.rdata);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        bit ok;
        int cyc;
        @(posedge clk); #1;
        m.data_wr    = v.wr;
        m.data_size  = v.size;
        m.data_wstrb = v.wstrb;
        m.data_wdata = v.wdata;
        m.data_addr  = v.is_data ? v.addr : ~v.addr;
        m.inst_addr  = v.is_data ? ~v.addr : v.addr;
        if (v.is_data) m.data_req = 1'b1;
        else           m.inst_req = 1'b1;
        wait_bus_req(v.name, ok, cyc);
        if (!ok) begin
            clear_inputs();
            return;
        end
        chk({v.name, "_req_latency"}, cyc, 1);
        // requester fields change after the grant; the latched copy must stay on the bus
        m.inst_addr  = ~m.inst_addr;
        m.data_addr  = ~m.data_addr;
        m.data_wdata = ~m.data_wdata;
        m.data_wr    = ~m.data_wr;
        m.data_wstrb = ~m.data_wstrb;
        chk({v.name, "_bus_addr"},  m.bus_addr,  v.exp_addr);
        chk({v.name, "_bus_wr"},    m.bus_wr,    v.exp_wr);
        chk({v.name, "_bus_size"},  m.bus_size,  v.exp_size);
        chk({v.name, "_bus_wstrb"}, m.bus_wstrb, v.exp_wstrb);
        chk({v.name, "_bus_wdata"}, m.bus_wdata, v.exp_wdata);
        chk({v.name, "_owner"},     owner,       v.is_data);
        m.bus_addr_ok = 1'b1;
        if (v.lat < 0) begin
            m.bus_data_ok = 1'b1;
            m.bus_rdata   = v.rdata;
        end
        sb_q.push_back('{v.is_data, v.rdata});
        @(negedge clk);
        chk({v.name, "_addr_ok"}, {m.inst_addr_ok, m.data_addr_ok}, v.is_data ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        clear_inputs();
        m.bus_rdata = 32'h0BAD_0BAD;
        if (v.lat >= 0) begin
            repeat (v.lat) begin @(posedge clk); #1; end
            m.bus_data_ok = 1'b1;
            m.bus_rdata   = v.rdata;
            @(posedge clk); #1;
            m.bus_data_ok = 1'b0;
            m.bus_rdata   = 32'h0BAD_0BAD;
        end
        chk({v.name, "_idle_after"}, busy, 0);
        chk({v.name, "_rdata_held"}, v.is_data ? m.data_rdata : m.inst_rdata, v.rdata);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok;
        int cyc;
        bit pat[10];
        //         name              dat wr sz  wstrb  addr          wdata         rdata         lat exp_addr      ewr esz estrb exp_wdata
        vecs[0] = '{"fetch_boot",     0, 1, 1, 4'hF, 32'hBFC00000, 32'hCAFEF00D, 32'h3C1D0000, 1, 32'hBFC00000, 0, 2, 4'h0, 32'h0};
        vecs[1] = '{"load_byte_same", 1, 0, 0, 4'h0, 32'h80000003, 32'h0,        32'h000000AB, -1, 32'h80000003, 0, 0, 4'h0, 32'h0};
        vecs[2] = '{"store_word",     1, 1, 2, 4'hF, 32'h80000010, 32'h12345678, 32'h0,        0, 32'h80000010, 1, 2, 4'hF, 32'h12345678};
        vecs[3] = '{"store_half",     1, 1, 1, 4'hC, 32'h80000022, 32'hBEEF0000, 32'h0,        2, 32'h80000022, 1, 1, 4'hC, 32'hBEEF0000};
        vecs[4] = '{"load_word_slow", 1, 0, 2, 4'h0, 32'h80000040, 32'hFFFFFFFF, 32'h89ABCDEF, 3, 32'h80000040, 0, 2, 4'h0, 32'hFFFFFFFF};
        vecs[5] = '{"fetch_fast",     0, 0, 0, 4'h3, 32'hBFC00004, 32'h11111111, 32'h24080001, 0, 32'hBFC00004, 0, 2, 4'h0, 32'h0};
        vecs[6] = '{"post_reset",     0, 1, 2, 4'hF, 32'hBFC00200, 32'h77777777, 32'h00000021, 1, 32'hBFC00200, 0, 2, 4'h0, 32'h0};

        m.inst_req = 0; m.inst_addr = 0;
        m.data_req = 0; m.data_wr = 0; m.data_size = 0; m.data_wstrb = 0;
        m.data_addr = 0; m.data_wdata = 0;
        m.bus_addr_ok = 0; m.bus_data_ok = 0; m.bus_rdata = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    busy,      0);
        chk("rst_bus_req", m.bus_req, 0);
        chk("rst_owner",   owner,     0);
        chk("rst_fields",  {m.bus_wr, m.bus_size, m.bus_wstrb, m.bus_addr, m.bus_wdata} == '0, 1);
        chk("rst_oks",     {m.inst_addr_ok, m.inst_data_ok, m.data_addr_ok, m.data_data_ok}, 0);
        chk("rst_rdata",   {m.inst_rdata, m.data_rdata}, 0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // simultaneous requests: data first, inst on the next IDLE cycle
        @(posedge clk); #1;
        m.inst_req = 1; m.inst_addr = 32'hBFC00100;
        m.data_req = 1; m.data_wr = 1; m.data_size = 2; m.data_wstrb = 4'hF;
        m.data_addr = 32'h80000010; m.data_wdata = 32'h12345678;
        wait_bus_req("simul_data", ok, cyc);
        if (ok) begin
            chk("simul_owner_data", owner, 1);
            chk("simul_bus_wr",     m.bus_wr, 1);
            chk("simul_bus_wstrb",  m.bus_wstrb, 4'hF);
            chk("simul_bus_addr",   m.bus_addr, 32'h80000010);
            m.bus_addr_ok = 1;
            sb_q.push_back('{1'b1, 32'h0});
            @(negedge clk);
            chk("simul_addr_ok", {m.inst_addr_ok, m.data_addr_ok}, 2'b01);
            @(posedge clk); #1;
            m.data_req = 0; m.bus_addr_ok = 0;
            m.bus_data_ok = 1; m.bus_rdata = 32'h0;
            @(posedge clk); #1;
            m.bus_data_ok = 0;
            chk("simul_idle_gap", busy, 0);
            @(posedge clk); #1;
            chk("simul_inst_grant", {busy, owner, m.bus_req}, 3'b101);
            chk("simul_inst_addr",  m.bus_addr, 32'hBFC00100);
            m.bus_addr_ok = 1; m.bus_data_ok = 1; m.bus_rdata = 32'h03E00008;
            sb_q.push_back('{1'b0, 32'h03E00008});
            @(posedge clk); #1;
        end
        clear_inputs();

        // starvation: both held high, 2-cycle transactions
        foreach (pat[k]) pat[k] = !(k == 4 || k == 9);
        @(posedge clk); #1;
        m.data_req = 1; m.data_wr = 0; m.data_size = 2; m.data_addr = 32'h80000100;
        m.inst_req = 1; m.inst_addr = 32'hBFC00300;
        for (int k = 0; k < 10; k++) begin
            wait_bus_req($sformatf("starve_%0d", k), ok, cyc);
            if (!ok) break;
            chk($sformatf("starve_owner_%0d", k), owner, pat[k]);
            m.bus_addr_ok = 1;
            sb_q.push_back('{pat[k], 32'hA0000000 + k});
            @(posedge clk); #1;
            m.bus_addr_ok = 0;
            m.bus_data_ok = 1; m.bus_rdata = 32'hA0000000 + k;
            if (k == 9) begin m.data_req = 0; m.inst_req = 0; end
            @(posedge clk); #1;
            m.bus_data_ok = 0;
            chk($sformatf("starve_gap_%0d", k), busy, 0);
        end
        clear_inputs();
        @(posedge clk); #1;
        chk("starve_quiet", busy, 0);

        // stray data_ok while the address is still pending
        m.data_req = 1; m.data_wr = 0; m.data_size = 2; m.data_addr = 32'h80000020;
        wait_bus_req("stray", ok, cyc);
        if (ok) begin
            m.bus_data_ok = 1; m.bus_rdata = 32'hDEADBEEF;
            @(negedge clk);
            chk("stray_no_ok", {m.inst_addr_ok, m.inst_data_ok, m.data_addr_ok, m.data_data_ok}, 0);
            @(posedge clk); #1;
            chk("stray_still_addr", {busy, m.bus_req}, 2'b11);
            m.bus_data_ok = 0; m.bus_addr_ok = 1;
            sb_q.push_back('{1'b1, 32'h600DF00D});
            @(posedge clk); #1;
            m.data_req = 0; m.bus_addr_ok = 0;
            m.bus_data_ok = 1; m.bus_rdata = 32'h600DF00D;
            @(posedge clk); #1;
            m.bus_data_ok = 0;
            chk("stray_done", busy, 0);
        end
        clear_inputs();

        // reset asserted while in DATA
        @(posedge clk); #1;
        m.inst_req = 1; m.inst_addr = 32'hBFC00400;
        wait_bus_req("rst_mid", ok, cyc);
        if (ok) begin
            m.bus_addr_ok = 1;
            @(posedge clk); #1;
            m.inst_req = 0; m.bus_addr_ok = 0;
            chk("rst_mid_in_data", busy, 1);
            #2;
            resetn = 0;
            m.bus_data_ok = 1; m.bus_rdata = 32'h5A5A5A5A;
            #1;
            chk("rst_mid_busy",    busy, 0);
            chk("rst_mid_bus_req", m.bus_req, 0);
            chk("rst_mid_oks",     {m.inst_addr_ok, m.inst_data_ok, m.data_addr_ok, m.data_data_ok}, 0);
            chk("rst_mid_rdata",   m.inst_rdata, 0);
            @(posedge clk); #1;
            m.bus_data_ok = 0;
            @(posedge clk); #1;
            resetn = 1;
        end
        clear_inputs();
        resetn = 1;
        run_vec(vecs[6]);

        repeat (2) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
